guess_game_ctrl: RTL

Game controller for the guess-the-number design. Sits directly downstream of the 4-bit LFSR: on a new-game request it latches the LFSR's current value as the secret. It then accepts player guesses from switches on each submit press, flags each guess as too high, too low or correct, and counts down the remaining tries. Its outputs drive the display/LED stage.

---
 rtl/guess_pkg.sv | 20 ++
 rtl/guess_game_ctrl_rise_det.sv | 19 +
 rtl/guess_game_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/guess_pkg.sv
// Shared definitions for the guess-the-number design: data width and FSM encoding.
package guess_pkg;

   localparam int GUESS_WIDTH = 4;
   localparam int TRIES_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WIN  = 2'd2,
      LOSE = 2'd3
   } game_state_t;

   typedef enum logic [1:0] {
      CMP_EQ   = 2'd0,
      CMP_HIGH = 2'd1,
      CMP_LOW  = 2'd2
   } cmp_t;

endpackage

// File: rtl/guess_game_ctrl_rise_det.sv
// Rising-edge detector for a debounced button level.
module rise_det (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic rise
);

   logic prev_reg;

   // Resetting to 1 keeps a button held through reset from looking like a press.
   always_ff @(posedge clk) begin
      if (reset) prev_reg <= 1'b1;
      else       prev_reg <= in;
   end

   assign rise = in & ~prev_reg;

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-the-number game controller: latches the LFSR value as the secret on a
// new-game press, grades each submitted guess and counts down remaining tries.
module guess_game_ctrl
   import guess_pkg::*;
#(
   parameter int WIDTH     = GUESS_WIDTH,
   parameter int MAX_TRIES = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   rnd,
   input  logic               start,
   input  logic               submit,
   input  logic [WIDTH-1:0]   guess,
   output logic               too_high,
   output logic               too_low,
   output logic               win,
   output logic               lose,
   output logic               playing,
   output logic [TRIES_W-1:0] tries_left,
   output logic [WIDTH-1:0]   secret_out
);

   localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);

   // Index 0 = start, index 1 = submit.
   logic [1:0] btn_level;
   logic [1:0] btn_rise;
   logic       start_rise;
   logic       submit_rise;

   assign btn_level = {submit, start};

   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      rise_det u_rise (
         .clk   (clk),
         .reset (reset),
         .in    (btn_level[gi]),
         .rise  (btn_rise[gi])
      );
   end

   assign start_rise  = btn_rise[0];
   assign submit_rise = btn_rise[1];

   game_state_t        state_reg,    state_next;
   logic [WIDTH-1:0]   secret_reg,   secret_next;
   logic [TRIES_W-1:0] tries_reg,    tries_next;
   logic               too_high_reg, too_high_next;
   logic               too_low_reg,  too_low_next;
   logic               win_reg,      win_next;
   logic               lose_reg,     lose_next;
   cmp_t               cmp;

   always_comb begin
      if (guess == secret_reg)     cmp = CMP_EQ;
      else if (guess > secret_reg) cmp = CMP_HIGH;
      else                         cmp = CMP_LOW;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         secret_reg   <= '0;
         tries_reg    <= '0;
         too_high_reg <= 1'b0;
         too_low_reg  <= 1'b0;
         win_reg      <= 1'b0;
         lose_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         secret_reg   <= secret_next;
         tries_reg    <= tries_next;
         too_high_reg <= too_high_next;
         too_low_reg  <= too_low_next;
         win_reg      <= win_next;
         lose_reg     <= lose_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      secret_next   = secret_reg;
      tries_next    = tries_reg;
      too_high_next = too_high_reg;
      too_low_next  = too_low_reg;
      win_next      = win_reg;
      lose_next     = lose_reg;

      // A new-game press wins over a simultaneous submit, from any state.
      if (start_rise) begin
         state_next    = PLAY;
         secret_next   = rnd;
         tries_next    = TRIES_INIT;
         too_high_next = 1'b0;
         too_low_next  = 1'b0;
         win_next      = 1'b0;
         lose_next     = 1'b0;
      end else if (state_reg == PLAY && submit_rise) begin
         unique case (cmp)
            CMP_EQ: begin
               state_next    = WIN;
               win_next      = 1'b1;
               too_high_next = 1'b0;
               too_low_next  = 1'b0;
            end
            default: begin
               too_high_next = (cmp == CMP_HIGH);
               too_low_next  = (cmp == CMP_LOW);
               tries_next    = tries_reg - 1'b1;
               // Last try missed: the final hint stays visible alongside lose.
               if (tries_reg == TRIES_W'(1)) begin
                  state_next = LOSE;
                  lose_next  = 1'b1;
               end
            end
         endcase
      end
   end

   assign too_high   = too_high_reg;
   assign too_low    = too_low_reg;
   assign win        = win_reg;
   assign lose       = lose_reg;
   assign playing    = (state_reg == PLAY);
   assign tries_left = tries_reg;
   assign secret_out = (state_reg == WIN || state_reg == LOSE) ? secret_reg : '0;

endmodule
